// File: rtl/tmr_vote_scrub.sv
// ============================================================================
//  Module   : tmr_vote_scrub
//  Brief    : Majority voter for three register copies with a scrub
//             controller that rewrites disagreeing copies over a req/ack
//             handshake, re-checks them, and marks copies that keep
//             disagreeing after MAX_RETRY rewrites as stuck.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmr_vote_scrub #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic [WIDTH-1:0] voted,
    output logic [2:0]       err,
    output logic             scrub_req,
    output logic [2:0]       scrub_mask,
    output logic [WIDTH-1:0] scrub_data,
    input  logic             scrub_ack,
    output logic [2:0]       stuck,
    output logic [CNT_W-1:0] scrub_cnt
);

    // Retry counter only has to reach MAX_RETRY; keep at least one bit.
    localparam int                   c_RETRY_W   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX = c_RETRY_W'(MAX_RETRY);
    localparam logic [c_RETRY_W-1:0] c_RETRY_ONE = c_RETRY_W'(1);
    localparam logic [CNT_W-1:0]     c_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CHK1 = 2'd2,
        S_CHK2 = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [WIDTH-1:0]       r_voted;
    logic [2:0]             r_err;
    logic                   r_scrub_req;
    logic [2:0]             r_scrub_mask;
    logic [WIDTH-1:0]       r_scrub_data;
    logic [2:0]             r_stuck;
    logic [CNT_W-1:0]       r_cnt;
    logic [c_RETRY_W-1:0]   r_retry;

    // ------------------------------------------------------------------
    // Combinational voting and error classification
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]       w_majority;
    logic [WIDTH-1:0]       w_copy [3];
    logic [2:0]             w_err_next;
    logic [2:0]             w_eff;
    logic [2:0]             w_bad;
    logic [CNT_W-1:0]       w_cnt_inc;

    // Bitwise 2-of-3 majority; a single bit can never be wrong in two copies
    // at once without also being the majority, so the result is always defined.
    assign w_majority = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);

    assign w_copy[0] = in_a;
    assign w_copy[1] = in_b;
    assign w_copy[2] = in_c;

    // Per-copy disagreement against this cycle's majority.
    for (genvar g = 0; g < 3; g++) begin : g_copy_err
        assign w_err_next[g] = (w_copy[g] != w_majority);
    end

    // Stuck copies are excluded from triggering or re-triggering scrubs.
    assign w_eff = r_err & ~r_stuck;
    assign w_bad = r_err & r_scrub_mask & ~r_stuck;

    // Request counter saturates instead of wrapping.
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // ------------------------------------------------------------------
    // Output register stage for the voter
    // ------------------------------------------------------------------
    // Register the majority and per-copy disagreement flags every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_voted <= '0;
            r_err   <= '0;
        end else begin
            r_voted <= w_majority;
            r_err   <= w_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Scrub controller
    // ------------------------------------------------------------------
    // Issue rewrite requests, wait for the rewritten value to reach r_err,
    // then either finish, retry the still-bad copies, or mark them stuck.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_scrub_req  <= 1'b0;
            r_scrub_mask <= '0;
            r_scrub_data <= '0;
            r_stuck      <= '0;
            r_cnt        <= '0;
            r_retry      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_eff) begin
                        r_scrub_data <= r_voted;
                        r_scrub_mask <= w_eff;
                        r_retry      <= c_RETRY_ONE;
                        r_scrub_req  <= 1'b1;
                        r_cnt        <= w_cnt_inc;
                        r_state      <= S_REQ;
                    end
                end

                S_REQ: begin
                    // Data and mask stay untouched while the request is open.
                    if (scrub_ack) begin
                        r_scrub_req <= 1'b0;
                        r_state     <= S_CHK1;
                    end
                end

                S_CHK1: begin
                    // Rewritten copy is on the input now; r_err sees it next cycle.
                    r_state <= S_CHK2;
                end

                S_CHK2: begin
                    if (w_bad == 3'b000) begin
                        r_state <= S_IDLE;
                    end else if (r_retry < c_RETRY_MAX) begin
                        r_retry      <= r_retry + 1'b1;
                        r_scrub_mask <= w_bad;
                        r_scrub_data <= r_voted;
                        r_scrub_req  <= 1'b1;
                        r_cnt        <= w_cnt_inc;
                        r_state      <= S_REQ;
                    end else begin
                        r_stuck <= r_stuck | w_bad;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign voted      = r_voted;
    assign err        = r_err;
    assign scrub_req  = r_scrub_req;
    assign scrub_mask = r_scrub_mask;
    assign scrub_data = r_scrub_data;
    assign stuck      = r_stuck;
    assign scrub_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tmr_vote_scrub.sv
// ============================================================================
//  Module   : tb_tmr_vote_scrub
//  Brief    : Self-checking bench for tmr_vote_scrub: directed vector table,
//             hand-written multi-cycle sequences, and randomized traffic
//             compared against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmr_vote_scrub;

    localparam int WIDTH     = 8;
    localparam int CNT_W     = 8;
    localparam int MAX_RETRY = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_a, in_b, in_c;
    logic             scrub_ack;
    logic [WIDTH-1:0] voted;
    logic [2:0]       err;
    logic             scrub_req;
    logic [2:0]       scrub_mask;
    logic [WIDTH-1:0] scrub_data;
    logic [2:0]       stuck;
    logic [CNT_W-1:0] scrub_cnt;

    tmr_vote_scrub #(
        .WIDTH     (WIDTH),
        .CNT_W     (CNT_W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .voted      (voted),
        .err        (err),
        .scrub_req  (scrub_req),
        .scrub_mask (scrub_mask),
        .scrub_data (scrub_data),
        .scrub_ack  (scrub_ack),
        .stuck      (stuck),
        .scrub_cnt  (scrub_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, return at the following falling edge.
    task automatic tick(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic k);
        rst = r; in_a = a; in_b = b; in_c = c; scrub_ack = k;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs for one cycle, outputs after that edge
    // ------------------------------------------------------------------
    typedef struct {
        logic       r;
        logic [7:0] a, b, c;
        logic       k;
        logic [7:0] ev;
        logic [2:0] ee;
        logic       er;
        logic [2:0] em;
        logic [7:0] ed;
        logic [7:0] ec;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic k, input logic [7:0] ev,
                                input logic [2:0] ee, input logic er, input logic [2:0] em,
                                input logic [7:0] ed, input logic [7:0] ec);
        vec_t v;
        v.r = r; v.a = a; v.b = b; v.c = c; v.k = k;
        v.ev = ev; v.ee = ee; v.er = er; v.em = em; v.ed = ed; v.ec = ec;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: tracks an outstanding scrub as a transaction with a
    // timestamped re-check instead of explicit controller states.
    // ------------------------------------------------------------------
    logic [7:0] m_voted, m_data;
    logic [2:0] m_err, m_mask, m_stuck;
    logic       m_req, m_busy;
    int         m_cnt, m_tries, m_chk_at, m_cyc;

    task automatic model_step(input logic r, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic k);
        logic [7:0] nv;
        logic [2:0] ne, bad;
        if (r) begin
            m_voted = '0; m_err = '0; m_req = 1'b0; m_mask = '0; m_data = '0;
            m_stuck = '0; m_cnt = 0; m_busy = 1'b0; m_tries = 0; m_chk_at = -1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                int n;
                n = int'(a[i]) + int'(b[i]) + int'(c[i]);
                nv[i] = (n >= 2);
            end
            ne = {c != nv, b != nv, a != nv};
            if (m_req) begin
                if (k) begin
                    m_req    = 1'b0;
                    m_chk_at = m_cyc + 2;
                end
            end else if (m_chk_at == m_cyc) begin
                m_chk_at = -1;
                bad = m_err & m_mask & ~m_stuck;
                if (bad == 3'b000) begin
                    m_busy = 1'b0;
                end else if (m_tries < MAX_RETRY) begin
                    m_tries++;
                    m_mask = bad; m_data = m_voted; m_req = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    m_stuck = m_stuck | bad;
                    m_busy  = 1'b0;
                end
            end else if (!m_busy && ((m_err & ~m_stuck) != 3'b000)) begin
                m_busy = 1'b1; m_tries = 1;
                m_mask = m_err & ~m_stuck; m_data = m_voted; m_req = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            m_voted = nv;
            m_err   = ne;
        end
        m_cyc++;
    endtask

    // ------------------------------------------------------------------
    // Stimulus and checking
    // ------------------------------------------------------------------
    initial begin
        vec_t       tbl[$];
        int         reqs;
        bit         seen;
        logic [7:0] cp[3];
        logic [7:0] hf_bits;
        int         hf_idx;

        rst = 1'b1; in_a = '0; in_b = '0; in_c = '0; scrub_ack = 1'b0;
        m_cyc = 0;
        @(negedge clk);

        // ---- Table: clean, single upset, ignored ack, dual-copy scrub ----
        tbl.push_back(mk(1, 8'h5A, 8'h5A, 8'h5A, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 8'd0));
        tbl.push_back(mk(0, 8'h5A, 8'h5A, 8'h5A, 0, 8'h5A, 3'b000, 0, 3'b000, 8'h00, 8'd0));
        tbl.push_back(mk(0, 8'h5A, 8'h5A, 8'h5A, 0, 8'h5A, 3'b000, 0, 3'b000, 8'h00, 8'd0));
        tbl.push_back(mk(0, 8'h5A, 8'h5B, 8'h5A, 0, 8'h5A, 3'b010, 0, 3'b000, 8'h00, 8'd0));
        tbl.push_back(mk(0, 8'h5A, 8'h5A, 8'h5A, 0, 8'h5A, 3'b000, 1, 3'b010, 8'h5A, 8'd1));
        tbl.push_back(mk(0, 8'h5A, 8'h5A, 8'h5A, 0, 8'h5A, 3'b000, 1, 3'b010, 8'h5A, 8'd1));
        tbl.push_back(mk(0, 8'h5A, 8'h5A, 8'h5A, 1, 8'h5A, 3'b000, 0, 3'b000, 8'h00, 8'd1));
        tbl.push_back(mk(0, 8'h5A, 8'h5A, 8'h5A, 0, 8'h5A, 3'b000, 0, 3'b000, 8'h00, 8'd1));
        tbl.push_back(mk(0, 8'h5A, 8'h5A, 8'h5A, 1, 8'h5A, 3'b000, 0, 3'b000, 8'h00, 8'd1));
        tbl.push_back(mk(0, 8'h5A, 8'h5A, 8'h5A, 1, 8'h5A, 3'b000, 0, 3'b000, 8'h00, 8'd1));
        tbl.push_back(mk(0, 8'h01, 8'h02, 8'h00, 0, 8'h00, 3'b011, 0, 3'b000, 8'h00, 8'd1));
        tbl.push_back(mk(0, 8'h01, 8'h02, 8'h00, 0, 8'h00, 3'b011, 1, 3'b011, 8'h00, 8'd2));
        tbl.push_back(mk(0, 8'h01, 8'h02, 8'h00, 1, 8'h00, 3'b011, 0, 3'b000, 8'h00, 8'd2));
        tbl.push_back(mk(0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 8'd2));
        tbl.push_back(mk(0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 8'd2));
        tbl.push_back(mk(0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 8'd2));

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].k);
            chk($sformatf("tbl%0d voted", i), 32'(voted), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d err", i), 32'(err), 32'(tbl[i].ee));
            chk($sformatf("tbl%0d req", i), 32'(scrub_req), 32'(tbl[i].er));
            chk($sformatf("tbl%0d cnt", i), 32'(scrub_cnt), 32'(tbl[i].ec));
            chk($sformatf("tbl%0d stuck", i), 32'(stuck), 32'h0);
            if (tbl[i].er) begin
                chk($sformatf("tbl%0d mask", i), 32'(scrub_mask), 32'(tbl[i].em));
                chk($sformatf("tbl%0d data", i), 32'(scrub_data), 32'(tbl[i].ed));
            end
        end

        // ---- Stuck copy: c never takes the rewrite, ack always high ----
        tick(1, 8'h00, 8'h00, 8'h00, 0);
        reqs = 0;
        for (int i = 0; i < 30; i++) begin
            tick(0, 8'h00, 8'h00, 8'hFF, 1);
            if (scrub_req) begin
                reqs++;
                chk("stuck_seq mask", 32'(scrub_mask), 32'h4);
                chk("stuck_seq data", 32'(scrub_data), 32'h0);
            end
        end
        chk("stuck_seq requests", 32'(reqs), 32'd3);
        chk("stuck_seq stuck", 32'(stuck), 32'h4);
        chk("stuck_seq req idle", 32'(scrub_req), 32'h0);
        chk("stuck_seq voted", 32'(voted), 32'h0);
        chk("stuck_seq cnt", 32'(scrub_cnt), 32'd3);

        // ---- Delayed ack, then reset in the middle of a request ----
        tick(1, 8'h5A, 8'h5A, 8'h5A, 0);
        tick(0, 8'h5A, 8'h5A, 8'h5A, 0);
        tick(0, 8'h5A, 8'h5B, 8'h5A, 0);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            tick(0, 8'h5A, 8'h5A, 8'h5A, 0);
            seen = scrub_req;
        end
        chk("delay req seen", 32'(seen), 32'h1);
        for (int i = 0; i < 10; i++) begin
            chk("delay req held", 32'(scrub_req), 32'h1);
            chk("delay mask held", 32'(scrub_mask), 32'h2);
            chk("delay data held", 32'(scrub_data), 32'h5A);
            tick(0, 8'h5A, 8'h5A, 8'h5A, 0);
        end
        tick(1, 8'h5A, 8'h5A, 8'h5A, 0);
        chk("rst_mid req", 32'(scrub_req), 32'h0);
        chk("rst_mid voted", 32'(voted), 32'h0);
        chk("rst_mid err", 32'(err), 32'h0);
        chk("rst_mid mask", 32'(scrub_mask), 32'h0);
        chk("rst_mid data", 32'(scrub_data), 32'h0);
        chk("rst_mid stuck", 32'(stuck), 32'h0);
        chk("rst_mid cnt", 32'(scrub_cnt), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 8'h5A, 8'h5A, 8'h5A, 1);
            chk("idle_ack req", 32'(scrub_req), 32'h0);
            chk("idle_ack cnt", 32'(scrub_cnt), 32'h0);
        end

        // ---- Counter saturation: 260 one-shot upsets ----
        tick(1, 8'h00, 8'h00, 8'h00, 0);
        for (int n = 0; n < 260; n++) begin
            tick(0, 8'h01, 8'h00, 8'h00, 0);
            for (int j = 0; j < 6; j++) tick(0, 8'h00, 8'h00, 8'h00, 1);
            if (n == 99) chk("sat cnt100", 32'(scrub_cnt), 32'd100);
        end
        chk("sat cnt max", 32'(scrub_cnt), 32'd255);
        chk("sat stuck", 32'(stuck), 32'h0);

        // ---- Randomized traffic against the reference model ----
        cp[0] = 8'h3C; cp[1] = 8'h3C; cp[2] = 8'h3C;
        hf_bits = '0; hf_idx = 0;
        for (int i = 0; i < 3000; i++) begin
            logic       r, k, wr;
            logic [7:0] a, b, c, wd;
            logic [2:0] wm;
            r = (i == 0) || ($urandom_range(149) == 0);
            k = ($urandom_range(2) == 0);
            if (i % 500 == 0) begin
                hf_idx  = $urandom_range(2);
                hf_bits = ($urandom_range(1) == 1) ? (8'h01 << $urandom_range(7)) : 8'h00;
            end
            if ($urandom_range(29) == 0) begin
                cp[0] = 8'($urandom); cp[1] = cp[0]; cp[2] = cp[0];
            end
            if ($urandom_range(7) == 0) begin
                int ci;
                ci = $urandom_range(2);
                cp[ci] = cp[ci] ^ (8'h01 << $urandom_range(7));
            end
            a = cp[0] | ((hf_idx == 0) ? hf_bits : 8'h00);
            b = cp[1] | ((hf_idx == 1) ? hf_bits : 8'h00);
            c = cp[2] | ((hf_idx == 2) ? hf_bits : 8'h00);
            wr = scrub_req && k && !r;
            wm = scrub_mask;
            wd = scrub_data;
            tick(r, a, b, c, k);
            model_step(r, a, b, c, k);
            if (wr) begin
                for (int q = 0; q < 3; q++) if (wm[q]) cp[q] = wd;
            end
            chk("rnd voted", 32'(voted), 32'(m_voted));
            chk("rnd err", 32'(err), 32'(m_err));
            chk("rnd req", 32'(scrub_req), 32'(m_req));
            chk("rnd stuck", 32'(stuck), 32'(m_stuck));
            chk("rnd cnt", 32'(scrub_cnt), 32'(m_cnt));
            if (m_req) begin
                chk("rnd mask", 32'(scrub_mask), 32'(m_mask));
                chk("rnd data", 32'(scrub_data), 32'(m_data));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
